// File: rtl/ipsxe_fft_sdf_bf_stage.sv
`default_nettype none
// ============================================================================
// Module   : ipsxe_fft_sdf_bf_stage
// Purpose  : Radix-2 single-delay-feedback butterfly stage with external
//            feedback shift register; no scaling, rounding or twiddles.
// Revision : 1.0
// ============================================================================
module ipsxe_fft_sdf_bf_stage #(
    parameter int DATA_WIDTH = 16,
    parameter int DELAY      = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        clken,
    input  logic                        din_valid,
    input  logic                        din_sof,
    input  logic [DATA_WIDTH-1:0]       din_re,
    input  logic [DATA_WIDTH-1:0]       din_im,
    output logic                        fb_shift,
    output logic [2*(DATA_WIDTH+1)-1:0] fb_din,
    input  logic [2*(DATA_WIDTH+1)-1:0] fb_dout,
    output logic                        dout_valid,
    output logic                        dout_sof,
    output logic [DATA_WIDTH:0]         dout_re,
    output logic [DATA_WIDTH:0]         dout_im
);

    localparam int              c_CW    = $clog2(2 * DELAY);
    localparam int              c_OW    = DATA_WIDTH + 1;
    localparam logic [c_CW-1:0] c_DELAY = c_CW'(DELAY);
    localparam logic [c_CW-1:0] c_ONE   = c_CW'(1);

    logic [c_CW-1:0] r_cnt;
    logic            r_primed;
    logic            r_dout_valid;
    logic            r_dout_sof;
    logic [c_OW-1:0] r_dout_re;
    logic [c_OW-1:0] r_dout_im;

    logic            w_accept;
    logic [c_CW-1:0] w_cnt_eff;
    logic            w_phase;
    logic [c_OW-1:0] w_x_re;
    logic [c_OW-1:0] w_x_im;
    logic [c_OW-1:0] w_fb_re;
    logic [c_OW-1:0] w_fb_im;
    logic [c_OW-1:0] w_cand_re;
    logic [c_OW-1:0] w_cand_im;
    logic [c_OW-1:0] w_wr_re;
    logic [c_OW-1:0] w_wr_im;

    assign w_accept  = clken & din_valid;
    // A start-of-frame sample restarts the block regardless of the counter.
    assign w_cnt_eff = din_sof ? '0 : r_cnt;
    assign w_phase   = w_cnt_eff[c_CW-1];

    assign w_x_re  = {din_re[DATA_WIDTH-1], din_re};
    assign w_x_im  = {din_im[DATA_WIDTH-1], din_im};
    assign w_fb_re = fb_dout[c_OW-1:0];
    assign w_fb_im = fb_dout[2*c_OW-1:c_OW];

    always_comb begin
        w_cand_re = w_fb_re;
        w_cand_im = w_fb_im;
        w_wr_re   = w_x_re;
        w_wr_im   = w_x_im;
        if (w_phase) begin
            w_cand_re = w_fb_re + w_x_re;
            w_cand_im = w_fb_im + w_x_im;
            w_wr_re   = w_fb_re - w_x_re;
            w_wr_im   = w_fb_im - w_x_im;
        end
    end

    assign fb_shift = w_accept;
    assign fb_din   = {w_wr_im, w_wr_re};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt        <= '0;
            r_primed     <= 1'b0;
            r_dout_valid <= 1'b0;
            r_dout_sof   <= 1'b0;
            r_dout_re    <= '0;
            r_dout_im    <= '0;
        end else if (clken) begin
            if (din_valid) begin
                r_cnt        <= w_cnt_eff + c_ONE;
                r_primed     <= r_primed | w_phase;
                // Phase-0 outputs carry the previous block's differences,
                // which are only meaningful once a block has completed.
                r_dout_valid <= w_phase | r_primed;
                r_dout_sof   <= (w_cnt_eff == c_DELAY);
                r_dout_re    <= w_cand_re;
                r_dout_im    <= w_cand_im;
            end else begin
                r_dout_valid <= 1'b0;
                r_dout_sof   <= 1'b0;
            end
        end
    end

    assign dout_valid = r_dout_valid;
    assign dout_sof   = r_dout_sof;
    assign dout_re    = r_dout_re;
    assign dout_im    = r_dout_im;

endmodule
`default_nettype wire

// File: tb/tb_ipsxe_fft_sdf_bf_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_ipsxe_fft_sdf_bf_stage
// Purpose  : Self-checking bench: vector table, corner sequences, random run.
// Revision : 1.0
// ============================================================================
module tb_ipsxe_fft_sdf_bf_stage;

    localparam int DW = 16;
    localparam int DL = 4;
    localparam int OW = DW + 1;

    logic            clk;
    logic            rst;
    logic            clken;
    logic            din_valid;
    logic            din_sof;
    logic [DW-1:0]   din_re;
    logic [DW-1:0]   din_im;
    logic            fb_shift;
    logic [2*OW-1:0] fb_din;
    logic [2*OW-1:0] fb_dout;
    logic            dout_valid;
    logic            dout_sof;
    logic [OW-1:0]   dout_re;
    logic [OW-1:0]   dout_im;

    ipsxe_fft_sdf_bf_stage #(.DATA_WIDTH(DW), .DELAY(DL)) dut (
        .clk        (clk),
        .rst        (rst),
        .clken      (clken),
        .din_valid  (din_valid),
        .din_sof    (din_sof),
        .din_re     (din_re),
        .din_im     (din_im),
        .fb_shift   (fb_shift),
        .fb_din     (fb_din),
        .fb_dout    (fb_dout),
        .dout_valid (dout_valid),
        .dout_sof   (dout_sof),
        .dout_re    (dout_re),
        .dout_im    (dout_im)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External feedback shift register, DL strobes deep.
    logic [2*OW-1:0] sr [DL] = '{default: '0};
    always @(posedge clk) begin
        if (fb_shift) begin
            sr[0] <= fb_din;
            for (int i = 1; i < DL; i++) sr[i] <= sr[i-1];
        end
    end
    assign fb_dout = sr[DL-1];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Reference model: history of everything written to the feedback path.
    int m_cnt = 0;
    bit m_primed = 0;
    bit m_valid = 0;
    bit m_sof = 0;
    int m_re = 0;
    int m_im = 0;
    int h_re[$];
    int h_im[$];

    task automatic model_accept(input bit s, input int xr, input int xi);
        int eff, fr, fi;
        bit ph;
        eff = s ? 0 : m_cnt;
        ph  = (eff >= DL);
        fr  = h_re[h_re.size() - DL];
        fi  = h_im[h_im.size() - DL];
        if (ph) begin
            m_re = fr + xr;  m_im = fi + xi;
            h_re.push_back(fr - xr);  h_im.push_back(fi - xi);
        end else begin
            m_re = fr;  m_im = fi;
            h_re.push_back(xr);  h_im.push_back(xi);
        end
        if (h_re.size() > DL) begin
            void'(h_re.pop_front());
            void'(h_im.pop_front());
        end
        m_valid  = ph || m_primed;
        m_primed = m_primed || ph;
        m_sof    = (eff == DL);
        m_cnt    = (eff + 1) % (2 * DL);
    endtask

    task automatic chk_outputs(input string tag);
        chk({tag, ".valid"}, int'(dout_valid), int'(m_valid));
        chk({tag, ".sof"},   int'(dout_sof),   int'(m_sof));
        chk({tag, ".re"},    int'($signed(dout_re)), m_re);
        chk({tag, ".im"},    int'($signed(dout_im)), m_im);
    endtask

    task automatic step(input bit ce, input bit v, input bit s, input int re, input int im);
        clken = ce; din_valid = v; din_sof = s;
        din_re = 16'(re); din_im = 16'(im);
        #1;
        chk("fb_shift", int'(fb_shift), int'(ce & v));
        if (ce && v) model_accept(s, int'($signed(din_re)), int'($signed(din_im)));
        else if (ce) begin m_valid = 0; m_sof = 0; end
        @(posedge clk); #1;
        chk_outputs("step");
    endtask

    task automatic do_reset(input bit ce);
        rst = 1'b1; clken = ce; din_valid = 1'b0; din_sof = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        m_cnt = 0; m_primed = 0; m_valid = 0; m_sof = 0; m_re = 0; m_im = 0;
        chk_outputs("reset");
    endtask

    typedef struct {
        bit sof; int re; int im;
        bit ev;  bit es; int ere; int eim;
    } vec_t;
    vec_t tbl[$];

    function automatic void add(input bit s, input int r, input int i,
                                input bit ev, input bit es, input int er, input int ei);
        vec_t v;
        v.sof = s; v.re = r; v.im = i; v.ev = ev; v.es = es; v.ere = er; v.eim = ei;
        tbl.push_back(v);
    endfunction

    int got[$];

    initial begin
        for (int i = 0; i < DL; i++) begin h_re.push_back(0); h_im.push_back(0); end
        rst = 0; clken = 0; din_valid = 0; din_sof = 0; din_re = '0; din_im = '0;

        // Frame 1: 1..8
        add(1, 1, 0, 0, 0, 0, 0);  add(0, 2, 0, 0, 0, 0, 0);
        add(0, 3, 0, 0, 0, 0, 0);  add(0, 4, 0, 0, 0, 0, 0);
        add(0, 5, 0, 1, 1, 6, 0);  add(0, 6, 0, 1, 0, 8, 0);
        add(0, 7, 0, 1, 0, 10, 0); add(0, 8, 0, 1, 0, 12, 0);
        // Frame 2: zeros flush the differences
        add(1, 0, 0, 1, 0, -4, 0); add(0, 0, 0, 1, 0, -4, 0);
        add(0, 0, 0, 1, 0, -4, 0); add(0, 0, 0, 1, 0, -4, 0);
        add(0, 0, 0, 1, 1, 0, 0);  add(0, 0, 0, 1, 0, 0, 0);
        add(0, 0, 0, 1, 0, 0, 0);  add(0, 0, 0, 1, 0, 0, 0);
        // Frame 3: extremes
        for (int i = 0; i < 4; i++) add(i == 0, -32768, 32767, 1, 0, 0, 0);
        for (int i = 0; i < 4; i++) add(0, 32767, -32768, 1, i == 0, -1, -1);
        // Frame 4 phase 0: extreme differences emerge
        for (int i = 0; i < 4; i++) add(i == 0, 0, 0, 1, 0, -65535, 65535);

        repeat (2) @(posedge clk);
        #1;
        do_reset(1'b0);
        for (int i = 0; i < tbl.size(); i++) begin
            step(1, 1, tbl[i].sof, tbl[i].re, tbl[i].im);
            chk("tbl.valid", int'(dout_valid), int'(tbl[i].ev));
            chk("tbl.sof",   int'(dout_sof),   int'(tbl[i].es));
            chk("tbl.re",    int'($signed(dout_re)), tbl[i].ere);
            chk("tbl.im",    int'($signed(dout_im)), tbl[i].eim);
        end

        // Frame 1 again with idle and disabled cycles interleaved
        do_reset(1'b1);
        got.delete();
        for (int i = 1; i <= 8; i++) begin
            step(1, 1, i == 1, i, 0);
            if (dout_valid) got.push_back(int'($signed(dout_re)));
            step(1, 0, 0, 99, 99);
            chk("gap.valid_low", int'(dout_valid), 0);
            step(0, 1, 1, 77, 77);
            chk("gap.valid_low_ce0", int'(dout_valid), 0);
        end
        chk("gap.count", got.size(), 4);
        for (int i = 0; i < got.size() && i < 4; i++) chk("gap.sum", got[i], 6 + 2 * i);

        // Start of frame forced at cnt=6
        do_reset(1'b0);
        for (int i = 0; i < 6; i++) step(1, 1, i == 0, 10 + i, -i);
        step(1, 1, 1, 20, 3);
        for (int i = 0; i < 3; i++) step(1, 1, 0, 21 + i, 4 + i);
        step(1, 1, 0, 30, 1);
        chk("sof_restart.sof", int'(dout_sof), 1);

        // Reset at cnt=5
        for (int i = 0; i < 5; i++) step(1, 1, i == 0, 100 + i, 50 - i);
        do_reset(1'b1);
        for (int i = 0; i < 4; i++) begin
            step(1, 1, 0, 7 * i, 3 * i);
            chk("post_rst.valid", int'(dout_valid), 0);
        end
        step(1, 1, 0, 5, 5);
        chk("post_rst.first_sum_valid", int'(dout_valid), 1);
        chk("post_rst.first_sum_sof", int'(dout_sof), 1);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(99) == 0) do_reset(1'($urandom_range(1)));
            else step(1'($urandom_range(9) != 0), 1'($urandom_range(3) != 0),
                      1'($urandom_range(19) == 0),
                      int'($signed(16'($urandom))), int'($signed(16'($urandom))));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
